// File: rtl/cmem_pkg.sv
// Shared constants and state encoding for the coefficient memory controller.
package cmem_pkg;

    localparam int CMEM_DW    = 20;
    localparam int CMEM_AW    = 8;
    localparam int CMEM_DEPTH = 1 << CMEM_AW;

    // cmem control pins are active-low
    localparam logic CMEM_ON  = 1'b0;
    localparam logic CMEM_OFF = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        READY
    } cmem_state_e;

endpackage

// File: rtl/cmem_rr_arb2.sv
// Two-way round-robin arbiter; grants only while en is high, pointer moves on grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    // requester favoured when both ask
    logic ptr;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11)
                gnt = ptr ? 2'b10 : 2'b01;
            else
                gnt = req;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= 1'b0;
        else if (gnt[0])
            ptr <= 1'b1;
        else if (gnt[1])
            ptr <= 1'b0;
    end

endmodule

// File: rtl/cmem_ctrl.sv
// Load sequencer and two-requester read arbiter for the coefficient memory.
// Owns every cmem pin; all cmem controls are registered.
module cmem_ctrl
    import cmem_pkg::*;
#(
    parameter int DW     = CMEM_DW,
    parameter int AW     = CMEM_AW,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_start,
    input  logic          ld_valid,
    input  logic [DW-1:0] ld_data,
    output logic          ld_ready,
    output logic          load_done,
    output logic          loaded,
    input  logic [1:0]    req,
    input  logic [2*AW-1:0] raddr,
    output logic [1:0]    gnt,
    output logic          rvalid,
    output logic          rid,
    output logic [DW-1:0] rdata,
    output logic          cmem_cen,
    output logic          cmem_wen,
    output logic [AW-1:0] cmem_caddr,
    output logic [DW-1:0] cmem_d,
    output logic [AW-1:0] cmem_a0,
    input  logic [DW-1:0] cmem_q0
);

    cmem_state_e   state;
    logic [AW-1:0] wcnt;
    logic          rd_en;
    logic          wr_fire;
    logic [RD_LAT:0] vld_pipe;
    logic [RD_LAT:0] id_pipe;

    // a reload request wins over any read in the same cycle
    assign rd_en   = (state == READY) && !load_start;
    assign wr_fire = (state == LOAD) && ld_valid && ld_ready;

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req (req),
        .en  (rd_en),
        .gnt (gnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wcnt      <= '0;
            ld_ready  <= 1'b0;
            load_done <= 1'b0;
            loaded    <= 1'b0;
        end else begin
            load_done <= 1'b0;
            case (state)
                IDLE, READY: begin
                    if (load_start) begin
                        state    <= LOAD;
                        wcnt     <= '0;
                        loaded   <= 1'b0;
                        ld_ready <= 1'b1;
                    end
                end
                LOAD: begin
                    if (ld_valid && ld_ready) begin
                        wcnt <= wcnt + 1'b1;
                        if (wcnt == '1) begin
                            state     <= READY;
                            ld_ready  <= 1'b0;
                            load_done <= 1'b1;
                            loaded    <= 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    ld_ready <= 1'b0;
                end
            endcase
        end
    end

    // write and read never coincide: grants only exist in READY
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmem_cen   <= CMEM_OFF;
            cmem_wen   <= CMEM_OFF;
            cmem_caddr <= '0;
            cmem_d     <= '0;
            cmem_a0    <= '0;
        end else begin
            cmem_cen <= CMEM_OFF;
            cmem_wen <= CMEM_OFF;
            cmem_d   <= '0;
            if (wr_fire) begin
                cmem_cen   <= CMEM_ON;
                cmem_wen   <= CMEM_ON;
                cmem_caddr <= wcnt;
                cmem_d     <= ld_data;
            end else if (|gnt) begin
                cmem_cen <= CMEM_ON;
                cmem_a0  <= gnt[1] ? raddr[2*AW-1:AW] : raddr[AW-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            id_pipe  <= '0;
            rdata    <= '0;
        end else begin
            vld_pipe <= {vld_pipe[RD_LAT-1:0], |gnt};
            id_pipe  <= {id_pipe[RD_LAT-1:0], gnt[1]};
            if (vld_pipe[RD_LAT-1])
                rdata <= cmem_q0;
        end
    end

    assign rvalid = vld_pipe[RD_LAT];
    assign rid    = id_pipe[RD_LAT];

endmodule

// File: tb/tb_cmem_ctrl.sv
// Directed/random bench for cmem_ctrl with a behavioural cmem and a content/arbitration model.
module tb_cmem_ctrl;

    localparam int DW = 20;
    localparam int AW = 8;
    localparam int RD_LAT = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_start, ld_valid, ld_ready, load_done, loaded;
    logic [DW-1:0] ld_data;
    logic [1:0]    req, gnt;
    logic [2*AW-1:0] raddr;
    logic          rvalid, rid;
    logic [DW-1:0] rdata;
    logic          cmem_cen, cmem_wen;
    logic [AW-1:0] cmem_caddr, cmem_a0;
    logic [DW-1:0] cmem_d, cmem_q0;

    cmem_ctrl #(.DW(DW), .AW(AW), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst),
        .load_start(load_start), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_ready(ld_ready), .load_done(load_done), .loaded(loaded),
        .req(req), .raddr(raddr), .gnt(gnt),
        .rvalid(rvalid), .rid(rid), .rdata(rdata),
        .cmem_cen(cmem_cen), .cmem_wen(cmem_wen), .cmem_caddr(cmem_caddr),
        .cmem_d(cmem_d), .cmem_a0(cmem_a0), .cmem_q0(cmem_q0)
    );

    always #5 clk = ~clk;

    // behavioural macro: synchronous write, read data follows A0 within the cycle
    logic [DW-1:0] mem [0:255];
    always @(posedge clk)
        if (cmem_cen === 1'b0 && cmem_wen === 1'b0) mem[cmem_caddr] <= cmem_d;
    assign cmem_q0 = mem[cmem_a0];

    int tests = 0, fails = 0;
    int cyc = 0, done_cnt = 0, xbad = 0;
    logic [AW-1:0] wq_a [$];
    logic [DW-1:0] wq_d [$];
    logic          rq_id [$];
    logic [DW-1:0] rq_d [$];
    int            rq_c [$], gq_c [$];
    logic          eq_id [$];
    logic [DW-1:0] eq_d [$];
    logic [DW-1:0] ref_mem [0:255];
    bit            nxt = 1'b0;
    logic [AW-1:0] last_a = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if ($isunknown({cmem_cen, cmem_wen})) xbad++;
        if (!rst) begin
            if (cmem_cen === 1'b0 && cmem_wen === 1'b0) begin
                wq_a.push_back(cmem_caddr);
                wq_d.push_back(cmem_d);
            end
            if (rvalid === 1'b1) begin
                rq_id.push_back(rid);
                rq_d.push_back(rdata);
                rq_c.push_back(cyc);
            end
            if (|gnt) gq_c.push_back(cyc);
            if (load_done === 1'b1) done_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clearq();
        rq_id.delete(); rq_d.delete(); rq_c.delete(); gq_c.delete();
        eq_id.delete(); eq_d.delete();
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_cen"}, 32'(cmem_cen), 1);
        chk({tag, "_wen"}, 32'(cmem_wen), 1);
        chk({tag, "_caddr"}, 32'(cmem_caddr), 0);
        chk({tag, "_d"}, 32'(cmem_d), 0);
        chk({tag, "_a0"}, 32'(cmem_a0), 0);
        chk({tag, "_ld_ready"}, 32'(ld_ready), 0);
        chk({tag, "_load_done"}, 32'(load_done), 0);
        chk({tag, "_loaded"}, 32'(loaded), 0);
        chk({tag, "_gnt"}, 32'(gnt), 0);
        chk({tag, "_rvalid"}, 32'(rvalid), 0);
        chk({tag, "_rid"}, 32'(rid), 0);
        chk({tag, "_rdata"}, 32'(rdata), 0);
    endtask

    // Streams words until 'stop' are accepted; a full load is checked against the model.
    task automatic load_all(input bit gaps, input int stop);
        int n, c, bad;
        bit v;
        logic [DW-1:0] w [0:255];
        n = 0; c = 0; bad = 0;
        wq_a.delete(); wq_d.delete(); gq_c.delete(); done_cnt = 0;
        req = 2'b11;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        while (n < stop && c < 4000) begin
            v = gaps ? (c % 2 == 0) : 1'b1;
            ld_valid = v;
            ld_data = 20'($urandom % 1048576);
            @(negedge clk);
            if (v && ld_ready === 1'b1) begin
                w[n] = ld_data;
                n++;
            end
            step();
            c++;
        end
        ld_valid = 1'b0;
        req = 2'b00;
        if (stop == 256) begin
            repeat (3) step();
            chk("load_accepted", n, 256);
            for (int i = 0; i < n; i++) ref_mem[i] = w[i];
            chk("wr_count", wq_a.size(), 256);
            for (int i = 0; i < wq_a.size() && i < n; i++)
                if (wq_a[i] !== 8'(i) || wq_d[i] !== w[i]) bad++;
            chk("wr_order", bad, 0);
            chk("load_done_pulses", done_cnt, 1);
            chk("loaded_set", 32'(loaded), 1);
            chk("ld_ready_idle", 32'(ld_ready), 0);
            chk("gnt_during_load", gq_c.size(), 0);
        end
    endtask

    task automatic issue(input logic [1:0] r, input logic [AW-1:0] a0v, input logic [AW-1:0] a1v);
        logic [1:0] g;
        req = r;
        raddr = {a1v, a0v};
        g = (r == 2'b11) ? (nxt ? 2'b10 : 2'b01) : r;
        @(negedge clk);
        chk("gnt", 32'(gnt), 32'(g));
        if (g != 2'b00) begin
            eq_id.push_back(g[1]);
            eq_d.push_back(ref_mem[g[1] ? a1v : a0v]);
            last_a = g[1] ? a1v : a0v;
            nxt = g[0];
        end
        step();
    endtask

    task automatic drain(input string tag);
        int bad;
        bad = 0;
        req = 2'b00;
        repeat (RD_LAT + 3) step();
        chk({tag, "_nreads"}, rq_d.size(), eq_d.size());
        chk({tag, "_ngrants"}, gq_c.size(), eq_d.size());
        for (int i = 0; i < rq_d.size() && i < eq_d.size() && i < gq_c.size(); i++)
            if (rq_id[i] !== eq_id[i] || rq_d[i] !== eq_d[i] || rq_c[i] - gq_c[i] != RD_LAT + 1) bad++;
        chk({tag, "_data"}, bad, 0);
        clearq();
    endtask

    initial begin
        rst = 1'b1; load_start = 1'b0; ld_valid = 1'b0; ld_data = '0;
        req = 2'b11; raddr = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset("rst");
        rst = 1'b0; req = 2'b00;
        step();

        // full load, then reload from READY with gaps
        load_all(1'b0, 256);
        load_all(1'b1, 256);

        // contention: alternating grants
        clearq();
        repeat (4) issue(2'b11, 8'h05, 8'hA0);
        drain("rr4");

        // single requester sweep, back-to-back
        clearq();
        for (int i = 0; i < 256; i++) issue(2'b01, 8'(i), 8'h00);
        drain("sweep");

        // random request mix
        clearq();
        for (int i = 0; i < 80; i++) issue(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
        drain("rand");
        chk("idle_cen", 32'(cmem_cen), 1);
        chk("idle_a0_hold", 32'(cmem_a0), 32'(last_a));

        // reset with a read in flight drops it
        clearq();
        issue(2'b01, 8'h07, 8'h00);
        rst = 1'b1; nxt = 1'b0;
        #1;
        chk("rst_inflight_rvalid", 32'(rvalid), 0);
        step(); rst = 1'b0;
        repeat (4) step();
        chk("rst_discard", rq_d.size(), 0);
        chk("rst_loaded", 32'(loaded), 0);
        clearq();
        load_all(1'b0, 256);

        // reload requested while a read is in flight
        clearq();
        issue(2'b10, 8'h00, 8'h33);
        load_start = 1'b1; req = 2'b11; raddr = 16'h1122;
        @(negedge clk);
        chk("gnt_on_load_start", 32'(gnt), 0);
        step();
        load_start = 1'b0; req = 2'b00;
        @(negedge clk);
        chk("fsm_load_ready", 32'(ld_ready), 1);
        chk("reload_loaded", 32'(loaded), 0);
        drain("inflight");

        // reset part-way through a load, then full reload and read back 99
        rst = 1'b1; nxt = 1'b0;
        step(); rst = 1'b0; step();
        load_all(1'b0, 100);
        req = 2'b11;
        rst = 1'b1;
        #1;
        chk_reset("midload");
        step(); rst = 1'b0; req = 2'b00; step();
        load_all(1'b0, 256);
        clearq();
        issue(2'b10, 8'h00, 8'd99);
        drain("addr99");

        chk("cen_wen_known", xbad, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cmem_ctrl.md
Name: cmem_ctrl

Overview:
Sequencer and read arbiter for the 256 x 20 coefficient memory (cmem).
- Runs a load phase that streams 256 words into cmem at addresses 0..255.
- Then shares the cmem read port between two requesters using round-robin arbitration.
- Sits between the coefficient loader / compute engines and the cmem macro, and owns every cmem control pin.

Parameters:
- DW, 20, cmem data width
- AW, 8, cmem address width; depth = 2**AW
- RD_LAT, 1, cycles from A0 driven at a clk rising edge to Q0 valid for capture

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- load_start  in  1  pulse; begins (re)load
- ld_valid  in  1  load word present
- ld_data  in  DW  load word
- ld_ready  out  1  load word accepted this cycle
- load_done  out  1  one-cycle pulse after the last write
- loaded  out  1  cmem contents valid
- req  in  2  read request per requester
- raddr  in  2*AW  read address; [AW-1:0] for requester 0, [2*AW-1:AW] for requester 1
- gnt  out  2  one-hot grant; the request is consumed in this cycle
- rvalid  out  1  read data valid
- rid  out  1  requester index for rdata
- rdata  out  DW  read data
- cmem_cen  out  1  chip enable to cmem, active-low
- cmem_wen  out  1  write enable to cmem, active-low
- cmem_caddr  out  AW  write address
- cmem_d  out  DW  write data
- cmem_a0  out  AW  read address
- cmem_q0  in  DW  read data from cmem

Behaviour:
- Reset values (async, immediate):
  - cmem_cen=1, cmem_wen=1.
  - cmem_caddr=0, cmem_d=0, cmem_a0=0.
  - ld_ready=0, load_done=0, loaded=0, gnt=0, rvalid=0, rid=0, rdata=0.
  - FSM=IDLE, rr pointer=0, write counter=0.
- FSM states: IDLE, LOAD, READY.
  - IDLE: load_start -> LOAD, counter=0, loaded=0.
  - LOAD: ld_ready=1.
    - Each cycle with ld_valid=1: register cmem_cen=0, cmem_wen=0, cmem_caddr=counter, cmem_d=ld_data; counter++.
    - Cycles with ld_valid=0: cmem_cen=1, cmem_wen=1; counter holds.
    - When the word at counter=255 is accepted: next cycle FSM=READY, load_done=1 for exactly one cycle, loaded=1.
  - READY:
    - load_start -> LOAD; counter=0 and loaded=0 on the next cycle.
    - Any in-flight read data is still delivered.
    - A grant is never issued in the cycle load_start is sampled.
- Load write timing: cmem control/data are registered, so a write reaches cmem one cycle after the ld_valid&&ld_ready handshake.
- ld_ready is 0 outside LOAD. Words offered outside LOAD are ignored.
- Counter is AW bits. The 256th write ends LOAD, so counter wrap is never used for addressing.
- Arbitration (READY only, and no load_start):
  - Single requester: granted immediately.
  - Both requesting: grant the requester ≠ last granted. rr pointer starts at 0, so requester 0 wins first.
  - gnt is combinational from req and the rr pointer. rr pointer updates on grant.
  - At most one grant per cycle; back-to-back grants every cycle are allowed.
  - req is ignored in IDLE/LOAD (gnt=0).
- Read pipeline:
  - On grant: cmem_a0 <= granted raddr, cmem_cen=0, cmem_wen=1.
  - Capture cmem_q0 RD_LAT cycles after cmem_a0 updates; present it as rdata with rvalid=1 and rid=granted index for one cycle.
  - Total latency grant -> rvalid = RD_LAT+1 cycles.
  - Pipeline is a RD_LAT+1-deep shift of {valid, id}.
- Idle read cycles: cmem_cen=1. cmem_a0 holds its last value.
- Reset mid-operation: everything returns to reset values. Pending reads are discarded (no rvalid). loaded=0 until a full reload.
- CEN/WEN never go X. cmem_d is driven 0 outside writes; the bus is never tri-stated.

Decomposition:
- Shared package cmem_pkg:
  - CMEM_DW=20, CMEM_AW=8, CMEM_DEPTH=256.
  - Active-low constants CMEM_ON=1'b0, CMEM_OFF=1'b1.
  - FSM state encoding typedef {IDLE, LOAD, READY}.
- One sub-module: rr_arb2 (2-way round-robin arbiter: req, grant-accept, gnt, pointer).

Test Plan:
- Reset then load_start with 256 consecutive ld_valid words (values $urandom%1048576) -> 256 writes to caddr 0..255 in order, cmem_wen=0 only on those cycles, load_done pulse exactly once, loaded=1.
- Load with ld_valid toggling 1,0,1,0 -> writes only on valid cycles, addresses contiguous, no write on gaps, load_done after the 256th accepted word.
- READY, req=2'b11 held for 4 cycles with raddr0=8'h05, raddr1=8'hA0 -> gnt sequence 01,10,01,10; rvalid after RD_LAT+1 cycles with rid 0,1,0,1 and rdata = the words loaded at 0x05/0xA0.
- req=2'b01 only, raddr0 swept 0..255 -> 256 grants back-to-back, rdata matches loaded contents, rid=0 throughout.
- Assert rst mid-load at word 100 -> outputs at reset values within the same cycle, loaded=0; a later full load and read of address 99 returns the new word.
- load_start in READY with one read in flight -> that rvalid still returned, no gnt in the load_start cycle, FSM in LOAD, loaded=0.
